// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared memory-interface widths and client identifiers for the
// icache/dcache memory request arbiter.
//   MEM_ADDR_BITS  - line address width
//   MEM_TAG_BITS   - memory request/response tag width
//   MEM_DATA_BITS  - data beat width (MEM_MASK_BITS = one mask bit per byte)
//   ARB_IC/ARB_DC  - client ids carried in the low bit of the memory tag
package mem_req_arbiter_pkg;

  localparam int unsigned MEM_ADDR_BITS = 32;
  localparam int unsigned MEM_TAG_BITS  = 4;
  localparam int unsigned MEM_DATA_BITS = 64;
  localparam int unsigned MEM_MASK_BITS = MEM_DATA_BITS / 8;

  localparam logic ARB_IC = 1'b0;
  localparam logic ARB_DC = 1'b1;

  // Memory tag for a client: zero-extended client id.
  function automatic logic [MEM_TAG_BITS-1:0] client_tag(input logic id);
    logic [MEM_TAG_BITS-1:0] tag;
    tag    = '0;
    tag[0] = id;
    return tag;
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates icache line fills and dcache fills/write-backs onto a single
// memory port, one transaction outstanding at a time.
//   clk, reset (async, active-low)
//   ic_req_*  : icache fill request; ic_resp_valid marks resp_data beats for the icache
//   dc_req_*  : dcache request (rw=1 write-back); dc_data_* write beats; dc_resp_valid
//   mem_req_*      : memory request channel (addr, rw, tag = client id)
//   mem_req_data_* : memory write-data channel, passed through from the dcache
//   mem_resp_*     : memory response; beats with a non-matching tag are dropped
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests;
// otherwise the dcache always wins.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned DATA_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_req_addr,
  output logic                     ic_resp_valid,
  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic                     dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0] dc_req_addr,
  input  logic                     dc_data_valid,
  output logic                     dc_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_data_mask,
  output logic                     dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0] resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]  mem_req_tag,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]  mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  localparam int unsigned    CntW     = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(DATA_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRresp} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic                     rw_q;
  logic                     id_q;
  logic [MEM_TAG_BITS-1:0]  tag_full;
  logic                     grant, grant_dc, resp_hit, beat_fire;

  assign grant = (state_q == StIdle) && (ic_req_valid || dc_req_valid);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie, serve whichever client did not win the previous grant.
  assign grant_dc = dc_req_valid && (!ic_req_valid || (last_q == ARB_IC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= ARB_IC;
    end else if (grant) begin
      last_q <= grant_dc ? ARB_DC : ARB_IC;
    end
  end
`else
  assign grant_dc = dc_req_valid;
`endif

  assign tag_full  = client_tag(id_q);
  assign resp_hit  = (state_q == StRresp) && mem_resp_valid && (mem_resp_tag == tag_full);
  assign beat_fire = (state_q == StWdata) ? (dc_data_valid && mem_req_data_ready) : resp_hit;

  // State register and latched request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      id_q    <= ARB_IC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        addr_q <= grant_dc ? dc_req_addr : ic_req_addr;
        rw_q   <= grant_dc && dc_req_rw;  // icache never writes
        id_q   <= grant_dc ? ARB_DC : ARB_IC;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StAddr;
      end
      StAddr: begin
        if (mem_req_ready) begin
          state_d = rw_q ? StWdata : StRresp;
          cnt_d   = '0;
        end
      end
      StWdata, StRresp: begin
        if (beat_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StIdle;
        end
      end
    endcase
  end

  // Outputs. Request readies are gated by reset so nothing is acknowledged while it is held.
  always_comb begin
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    ic_resp_valid      = 1'b0;
    dc_resp_valid      = 1'b0;
    resp_data          = '0;
    dc_data_ready      = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_tag        = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    unique case (state_q)
      StIdle: begin
        ic_req_ready = reset && ic_req_valid && !grant_dc;
        dc_req_ready = reset && dc_req_valid && grant_dc;
      end
      StAddr: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = rw_q;
        mem_req_addr  = addr_q;
        mem_req_tag   = tag_full;
      end
      StWdata: begin
        mem_req_data_valid = dc_data_valid;
        dc_data_ready      = mem_req_data_ready;
        mem_req_data_bits  = dc_data_bits;
        mem_req_data_mask  = dc_data_mask;
      end
      StRresp: begin
        if (resp_hit) begin
          resp_data     = mem_resp_data;
          ic_resp_valid = (id_q == ARB_IC);
          dc_resp_valid = (id_q == ARB_DC);
        end
      end
    endcase
  end

endmodule
